// File: rtl/ysyx_24110015_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, MemOp encodings,
// byte-strobe masks and the access-legality check.
package ysyx_24110015_lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_e;

  localparam logic [2:0] MOP_B  = 3'b000;
  localparam logic [2:0] MOP_H  = 3'b001;
  localparam logic [2:0] MOP_W  = 3'b010;
  localparam logic [2:0] MOP_BU = 3'b100;
  localparam logic [2:0] MOP_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Illegal combination, undefined memop, unsigned store, or misaligned H/W.
  function automatic logic f_bad_access(input logic       ren,
                                        input logic       wen,
                                        input logic [2:0] memop,
                                        input logic [1:0] addr_lo);
    logic bad;
    bad = (ren & wen)
        | (memop == 3'b011)
        | (memop[2:1] == 2'b11)
        | (memop[2] & wen)
        | ((memop[1:0] == 2'b01) & addr_lo[0])
        | ((memop == MOP_W) & (addr_lo != 2'b00));
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_24110015_lsu_align.sv
// Byte-lane steering: store mask/data replication and load extract/extend.
// Purely combinational.
module ysyx_24110015_lsu_align
  import ysyx_24110015_lsu_pkg::*;
(
  input  logic [2:0]  i_memop,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_lane;

  assign w_lane = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_wmask = 4'b0000;
    o_wdata = i_wdata;
    o_rdata = 32'h0;
    unique case (i_memop)
      MOP_B: begin
        o_wmask = MASK_B << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
      end
      MOP_H: begin
        o_wmask = MASK_H << i_addr_lo;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{w_lane[15]}}, w_lane[15:0]};
      end
      MOP_W: begin
        o_wmask = MASK_W;
        o_rdata = i_rdata;
      end
      MOP_BU:  o_rdata = {24'h0, w_lane[7:0]};
      MOP_HU:  o_rdata = {16'h0, w_lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_24110015_lsu.sv
// Multi-cycle load/store unit: latches one EXU result, runs at most one bus access,
// then holds the write-back value until downstream accepts it.
module ysyx_24110015_lsu
  import ysyx_24110015_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_ren,
  input  logic              in_wen,
  input  logic [2:0]        in_memop,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic              mem_resp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wen;
  logic [2:0]        r_memop;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              w_err_nxt;
  logic              w_accept;
  logic [3:0]        w_wmask;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load;

  assign w_accept = (r_state == StIdle) && in_valid;

  // Steering works only on latched values, so no in_* path reaches mem_* or out_*.
  ysyx_24110015_lsu_align u_align (
    .i_memop   (r_memop),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (mem_resp_data),
    .o_wmask   (w_wmask),
    .o_wdata   (w_wdata),
    .o_rdata   (w_load)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          if (!in_ren && !in_wen) begin
            w_rdata_nxt = DATA_W'(in_addr);
            w_err_nxt   = 1'b0;
            w_state_nxt = StDone;
          end else if (f_bad_access(in_ren, in_wen, in_memop, in_addr[1:0])) begin
            w_rdata_nxt = '0;
            w_err_nxt   = 1'b1;
            w_state_nxt = StDone;
          end else begin
            w_state_nxt = StReq;
          end
        end
      end
      StReq: begin
        if (mem_req_ready) w_state_nxt = StWait;
      end
      StWait: begin
        if (mem_resp_valid) begin
          w_rdata_nxt = r_wen ? '0 : w_load;
          w_err_nxt   = mem_resp_err;
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        if (out_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wen   <= 1'b0;
      r_memop <= MOP_B;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_addr  <= in_addr;
        r_wdata <= in_wdata;
        r_wen   <= in_wen;
        r_memop <= in_memop;
      end
    end
  end

  assign in_ready      = (r_state == StIdle);
  assign mem_req_valid = (r_state == StReq);
  assign mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wen       = mem_req_valid && r_wen;
  assign mem_wmask     = mem_wen ? w_wmask : 4'b0000;
  assign mem_wdata     = w_wdata;
  assign out_valid     = (r_state == StDone);
  assign out_rdata     = r_rdata;
  assign out_err       = r_err;

endmodule
